// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs EX/MEM loads/stores on a req/ack data bus, stalls the pipeline,
// resolves branch redirect and selects write-back data. Optional REQ timeout via MEM_TIMEOUT_EN.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk_EXMem,
    input  logic        rst_EXMem,
    input  logic [31:0] alu_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] target_i,
    input  logic        zero_i,
    input  logic        branch_i,
    input  logic        branchn_i,
    input  logic        jump_i,
    input  logic        memrw_i,
    input  logic [1:0]  memtoreg_i,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall_o,
    output logic        pc_src_o,
    output logic [31:0] pc_target_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_d, we_d, misalign_d;
    logic [31:0] addr_d, wdata_d, rdata_q, rdata_d;
    logic        mem_op_c, aligned_c;

    // Elaboration guard: the counter must be able to reach TIMEOUT_CYCLES.
    if (TIMEOUT_CYCLES >= (32'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_c;
    logic             bus_err_d;

    assign expire_c = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
`endif

    assign mem_op_c  = memrw_i | (memtoreg_i == 2'b01);
    assign aligned_c = (alu_i[1:0] == 2'b00);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        req_d      = dm_req;
        we_d       = dm_we;
        addr_d     = dm_addr;
        wdata_d    = dm_wdata;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        bus_err_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_op_c) begin
                    if (aligned_c) begin
                        req_d   = 1'b1;
                        we_d    = memrw_i;
                        addr_d  = alu_i;
                        wdata_d = rs2_i;
                        state_d = S_REQ;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                        rdata_d    = 32'h0;
                        state_d    = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (dm_ack) begin
                    req_d   = 1'b0;
                    if (!dm_we) rdata_d = dm_rdata;
                    state_d = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (expire_c) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_EXMem or posedge rst_EXMem) begin
        if (rst_EXMem) begin
            state_q    <= S_IDLE;
            dm_req     <= 1'b0;
            dm_we      <= 1'b0;
            dm_addr    <= 32'h0;
            dm_wdata   <= 32'h0;
            rdata_q    <= 32'h0;
            misalign_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req     <= req_d;
            dm_we      <= we_d;
            dm_addr    <= addr_d;
            dm_wdata   <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_o <= misalign_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_EXMem or posedge rst_EXMem) begin
        if (rst_EXMem) begin
            cnt_q     <= '0;
            bus_err_o <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_o <= bus_err_d;
        end
    end
`else
    assign bus_err_o = 1'b0;
`endif

    // The pipeline may advance only once the FSM reaches DONE.
    assign stall_o = ((state_q == S_IDLE) & mem_op_c) | (state_q == S_REQ);

    assign pc_src_o    = (branch_i & zero_i) | (branchn_i & ~zero_i) | jump_i;
    assign pc_target_o = target_i;

    always_comb begin
        case (memtoreg_i)
            2'b00:   wb_data_o = alu_i;
            2'b01:   wb_data_o = rdata_q;
            2'b10:   wb_data_o = pc4_i;
            default: wb_data_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized self-checking bench for mem_stage_ctrl; transaction-level model of stall length,
// bus activity and write-back data. Exercises the timeout path when MEM_TIMEOUT_EN is defined.
module tb_mem_stage_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TO    = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TO    = 16;
`endif

    logic        clk_EXMem = 1'b0;
    logic        rst_EXMem = 1'b1;
    logic [31:0] alu_i = '0, rs2_i = '0, pc4_i = '0, target_i = '0;
    logic        zero_i = 1'b0, branch_i = 1'b0, branchn_i = 1'b0, jump_i = 1'b0, memrw_i = 1'b0;
    logic [1:0]  memtoreg_i = 2'b00;
    logic        dm_req, dm_we, dm_ack = 1'b0;
    logic [31:0] dm_addr, dm_wdata, dm_rdata = '0;
    logic        stall_o, pc_src_o, misalign_o, bus_err_o;
    logic [31:0] pc_target_o, wb_data_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_rdata = 32'h0;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk_EXMem(clk_EXMem), .rst_EXMem(rst_EXMem),
        .alu_i(alu_i), .rs2_i(rs2_i), .pc4_i(pc4_i), .target_i(target_i),
        .zero_i(zero_i), .branch_i(branch_i), .branchn_i(branchn_i), .jump_i(jump_i),
        .memrw_i(memrw_i), .memtoreg_i(memtoreg_i),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_EXMem = ~clk_EXMem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // One EX/MEM instruction held until the controller lets it advance; d = REQ cycles before ack.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [31:0] pc4,
                          input logic [31:0] tgt, input logic zero, input logic br,
                          input logic brn, input logic jmp, input logic memrw,
                          input logic [1:0] m2r, input int d, input logic [31:0] rd);
        logic mem, mis, ld, tout, req_exp, taken;
        int ns;
        logic [31:0] rq_new, wb_exp;
        mem   = memrw || (m2r == 2'b01);
        mis   = mem && (alu[1:0] != 2'b00);
        ld    = !memrw && (m2r == 2'b01);
        tout  = mem && !mis && TO_EN && (d >= TO);
        ns    = !mem ? 0 : mis ? 1 : tout ? TO + 1 : d + 2;
        rq_new = !mem ? m_rdata : (mis || tout) ? 32'h0 : ld ? rd : m_rdata;
        taken = jmp || (br && zero) || (brn && !zero);
        alu_i = alu; rs2_i = rs2; pc4_i = pc4; target_i = tgt;
        zero_i = zero; branch_i = br; branchn_i = brn; jump_i = jmp;
        memrw_i = memrw; memtoreg_i = m2r;
        for (int c = 0; c <= ns; c++) begin
            if (mem && !mis && c == d + 1) begin
                dm_ack = 1'b1; dm_rdata = rd;
            end else begin
                // Stray acks outside REQ must be ignored
                dm_ack   = (c == 0 || c == ns) ? 1'($urandom_range(0, 1)) : 1'b0;
                dm_rdata = $urandom;
            end
            @(negedge clk_EXMem);
            check("stall", 32'(stall_o), 32'(c < ns));
            req_exp = mem && !mis && (c >= 1) && (c < ns);
            check("dm_req", 32'(dm_req), 32'(req_exp));
            if (req_exp) begin
                check("dm_we", 32'(dm_we), 32'(memrw));
                check("dm_addr", dm_addr, alu);
                check("dm_wdata", dm_wdata, rs2);
            end
            check("misalign", 32'(misalign_o), 32'(mis && c == ns));
            check("bus_err", 32'(bus_err_o), 32'(tout && c == ns));
            if (c == 0) begin
                check("pc_src", 32'(pc_src_o), 32'(taken));
                check("pc_target", pc_target_o, tgt);
            end
            if (c == ns) begin
                case (m2r)
                    2'b00:   wb_exp = alu;
                    2'b01:   wb_exp = rq_new;
                    2'b10:   wb_exp = pc4;
                    default: wb_exp = 32'h0;
                endcase
                check("wb_data", wb_data_o, wb_exp);
            end
            @(posedge clk_EXMem); #1;
        end
        dm_ack  = 1'b0;
        m_rdata = rq_new;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  m2r;
        logic        st;
        int          kind, d;

        // Reset state; memtoreg=01 exposes the cleared read-data register
        memtoreg_i = 2'b01;
        @(negedge clk_EXMem);
        check("rst_req", 32'(dm_req), 32'h0);
        check("rst_misalign", 32'(misalign_o), 32'h0);
        check("rst_bus_err", 32'(bus_err_o), 32'h0);
        check("rst_wb", wb_data_o, 32'h0);
        check("rst_stall", 32'(stall_o), 32'h1);
        memtoreg_i = 2'b00;
        @(posedge clk_EXMem); #1;
        rst_EXMem = 1'b0;

        // Directed cases
        run_op(32'h100, 32'h0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1, 32'hCAFEF00D);
        run_op(32'h20, 32'h12345678, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 0, 32'h0);
        run_op(32'h0, 32'h0, 32'hC, 32'h400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 0, 32'h0);
        run_op(32'h0, 32'h0, 32'h10, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 0, 32'h0);
        run_op(32'h7, 32'h0, 32'h14, 32'h600, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 0, 32'h0);
        run_op(32'h102, 32'h0, 32'h18, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 0, 32'hDEAD);
        run_op(32'h200, 32'h0, 32'h1C, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 20, 32'h55AA);

        // Asynchronous reset during REQ, then a late ack
        alu_i = 32'h40; memrw_i = 1'b0; memtoreg_i = 2'b01; dm_ack = 1'b0;
        @(posedge clk_EXMem); #2;
        check("midreq_req", 32'(dm_req), 32'h1);
        rst_EXMem = 1'b1;
        #1;
        check("midreq_req_rst", 32'(dm_req), 32'h0);
        memtoreg_i = 2'b00;
        #1;
        check("midreq_stall", 32'(stall_o), 32'h0);
        check("midreq_addr", dm_addr, 32'h0);
        @(posedge clk_EXMem); #1;
        rst_EXMem = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'hBAD0BAD0;
        @(negedge clk_EXMem);
        check("late_ack_req", 32'(dm_req), 32'h0);
        check("late_ack_stall", 32'(stall_o), 32'h0);
        @(posedge clk_EXMem); #1;
        dm_ack = 1'b0;
        @(negedge clk_EXMem);
        check("late_ack_idle", 32'(dm_req), 32'h0);
        @(posedge clk_EXMem); #1;
        m_rdata = 32'h0;

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 20) : $urandom_range(0, 5);
            st = 1'b0;
            if (kind == 0) begin
                m2r = 2'($urandom_range(0, 2));
                if (m2r == 2'b01) m2r = 2'b11;
            end else if (kind == 1) begin
                m2r = 2'b01;
            end else begin
                st  = 1'b1;
                m2r = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b00;
            end
            run_op(a, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), st, m2r, d, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
